mnt_cpa_round: RTL and testbench

MNT_CPA_ROUND -- requirements
Module: mnt_cpa_round

---
 rtl/fpu_mul_pkg.sv | 48 ++++
 rtl/mnt_rne_round.sv | 24 ++
 rtl/mnt_cpa_round.sv | 154 +++++++++++++++
 tb/tb_mnt_cpa_round.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared types and helpers for the FP multiplier mantissa carry-propagate/round path.
// The MNT_CPA_SPLIT_EN build also uses split_pay_t for its extra low-half adder stage.
package fpu_mul_pkg;

   localparam int unsigned MNT_W     = 24;
   localparam int unsigned PROD_W    = 48;
   // Exponents travel at this width internally and are truncated to EXP_W at the output.
   localparam int unsigned EXP_MAX_W = 32;

   typedef struct packed {
      logic [MNT_W-1:0]     m;
      logic                 g;
      logic                 s;
      logic [EXP_MAX_W-1:0] e;
      logic                 sign;
      logic                 zero;
   } stage_pay_t;

   typedef struct packed {
      logic [MNT_W-1:0]     lo;
      logic                 lo_c;
      logic [MNT_W-1:0]     hi_c;
      logic [MNT_W-1:0]     hi_s;
      logic [EXP_MAX_W-1:0] e;
      logic                 sign;
   } split_pay_t;

   function automatic stage_pay_t normalise(input logic [PROD_W-1:0]    p,
                                            input logic [EXP_MAX_W-1:0] e,
                                            input logic                 sign);
      stage_pay_t r;
      if (p[PROD_W-1]) begin
         r.m = p[PROD_W-1 -: MNT_W];
         r.g = p[PROD_W-MNT_W-1];
         r.s = |p[PROD_W-MNT_W-2:0];
         r.e = e + {{(EXP_MAX_W-1){1'b0}}, 1'b1};
      end else begin
         r.m = p[PROD_W-2 -: MNT_W];
         r.g = p[PROD_W-MNT_W-2];
         r.s = |p[PROD_W-MNT_W-3:0];
         r.e = e;
      end
      r.sign = sign;
      r.zero = (p == '0);
      return r;
   endfunction

endpackage

// File: rtl/mnt_rne_round.sv
// Round-to-nearest-even of a 24-bit mantissa given guard and sticky bits.
module mnt_rne_round
   import fpu_mul_pkg::*;
(
   input  logic [MNT_W-1:0] m_i,
   input  logic             g_i,
   input  logic             s_i,
   output logic [MNT_W-1:0] m_o,
   output logic             cout_o,
   output logic             inexact_o
);

   logic           inc;
   logic [MNT_W:0] m_inc;

   always_comb begin
      inc       = g_i & (s_i | m_i[0]);
      m_inc     = {1'b0, m_i} + {{MNT_W{1'b0}}, inc};
      m_o       = m_inc[MNT_W-1:0];
      cout_o    = m_inc[MNT_W];
      inexact_o = g_i | s_i;
   end

endmodule

// File: rtl/mnt_cpa_round.sv
// Carry-propagate add, normalise and RNE round of a 24x24 mantissa product (valid/ready).
// Define MNT_CPA_SPLIT_EN to split the 48-bit add across two stages (3-stage pipeline).
module mnt_cpa_round
   import fpu_mul_pkg::*;
#(
   parameter int unsigned EXP_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [47:0]       carry,
   input  logic [47:0]       sum,
   input  logic [EXP_W-1:0]  exp_in,
   input  logic              sign_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [22:0]       frac_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic              sign_out,
   output logic              zero_out,
   output logic              inexact_out
);

   localparam int unsigned PadW = EXP_MAX_W - EXP_W;

   logic [EXP_MAX_W-1:0] exp_ext;
   stage_pay_t           pay_in;
   logic                 up_valid;
   logic                 s1_ready, s2_ready;
   logic                 v1_q, v1_d, v2_q, v2_d;
   stage_pay_t           pay1_q, pay1_d;

   assign exp_ext = {{PadW{1'b0}}, exp_in};

`ifdef MNT_CPA_SPLIT_EN
   split_pay_t     pa_q, pa_d, pa_in;
   logic           va_q, va_d, sa_ready;
   logic [MNT_W:0] lo_add;
   logic [MNT_W-1:0] hi_add;

   always_comb begin
      lo_add        = {1'b0, carry[MNT_W-1:0]} + {1'b0, sum[MNT_W-1:0]};
      pa_in.lo      = lo_add[MNT_W-1:0];
      pa_in.lo_c    = lo_add[MNT_W];
      pa_in.hi_c    = carry[PROD_W-1:MNT_W];
      pa_in.hi_s    = sum[PROD_W-1:MNT_W];
      pa_in.e       = exp_ext;
      pa_in.sign    = sign_in;
      sa_ready      = ~va_q | s1_ready;
      va_d          = sa_ready ? in_valid : va_q;
      pa_d          = (sa_ready & in_valid) ? pa_in : pa_q;
      // High half completes the add using the registered low-half carry.
      hi_add        = pa_q.hi_c + pa_q.hi_s + {{(MNT_W-1){1'b0}}, pa_q.lo_c};
      pay_in        = normalise({hi_add, pa_q.lo}, pa_q.e, pa_q.sign);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         va_q <= 1'b0;
         pa_q <= '0;
      end else begin
         va_q <= va_d;
         pa_q <= pa_d;
      end
   end

   assign up_valid = va_q;
   assign in_ready = sa_ready;
`else
   always_comb begin
      pay_in = normalise(carry + sum, exp_ext, sign_in);
   end

   assign up_valid = in_valid;
   assign in_ready = s1_ready;
`endif

   // Each stage accepts when empty or when its downstream is draining this cycle.
   always_comb begin
      s2_ready = ~v2_q | out_ready;
      s1_ready = ~v1_q | s2_ready;
      v1_d     = s1_ready ? up_valid : v1_q;
      pay1_d   = (s1_ready & up_valid) ? pay_in : pay1_q;
      v2_d     = s2_ready ? v1_q : v2_q;
   end

   logic [MNT_W-1:0]     m_rnd;
   logic                 rnd_cout, rnd_inexact;
   logic [EXP_MAX_W-1:0] e_sum;

   mnt_rne_round u_rne (
      .m_i       (pay1_q.m),
      .g_i       (pay1_q.g),
      .s_i       (pay1_q.s),
      .m_o       (m_rnd),
      .cout_o    (rnd_cout),
      .inexact_o (rnd_inexact)
   );

   logic [22:0]      frac_q, frac_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic             sign_q, sign_d, zero_q, zero_d, inexact_q, inexact_d;

   always_comb begin
      e_sum     = pay1_q.e + {{(EXP_MAX_W-1){1'b0}}, rnd_cout};
      frac_d    = frac_q;
      exp_d     = exp_q;
      sign_d    = sign_q;
      zero_d    = zero_q;
      inexact_d = inexact_q;
      if (s2_ready & v1_q) begin
         // Rounding carry-out leaves m_rnd == 0, which is already the right fraction.
         frac_d    = pay1_q.zero ? '0 : m_rnd[MNT_W-2:0];
         exp_d     = e_sum[EXP_W-1:0];
         sign_d    = pay1_q.sign;
         zero_d    = pay1_q.zero;
         inexact_d = ~pay1_q.zero & rnd_inexact;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         pay1_q    <= '0;
         frac_q    <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         zero_q    <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         pay1_q    <= pay1_d;
         frac_q    <= frac_d;
         exp_q     <= exp_d;
         sign_q    <= sign_d;
         zero_q    <= zero_d;
         inexact_q <= inexact_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{e_sum[EXP_MAX_W-1:EXP_W], m_rnd[MNT_W-1]};

   assign out_valid   = v2_q;
   assign frac_out    = frac_q;
   assign exp_out     = exp_q;
   assign sign_out    = sign_q;
   assign zero_out    = zero_q;
   assign inexact_out = inexact_q;

endmodule

// File: tb/tb_mnt_cpa_round.sv
// Scoreboard bench for mnt_cpa_round; expected latency follows MNT_CPA_SPLIT_EN.
module tb_mnt_cpa_round;

`ifdef MNT_CPA_SPLIT_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [47:0] carry = '0;
   logic [47:0] sum = '0;
   logic [9:0]  exp_in = '0;
   logic        sign_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [22:0] frac_out;
   logic [9:0]  exp_out;
   logic        sign_out, zero_out, inexact_out;

   mnt_cpa_round #(.EXP_W(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .carry       (carry),
      .sum         (sum),
      .exp_in      (exp_in),
      .sign_in     (sign_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .frac_out    (frac_out),
      .exp_out     (exp_out),
      .sign_out    (sign_out),
      .zero_out    (zero_out),
      .inexact_out (inexact_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [22:0] frac;
      logic [9:0]  e;
      logic        sg;
      logic        z;
      logic        ix;
   } res_t;

   typedef struct {
      logic [47:0] c;
      logic [47:0] s;
      logic [9:0]  e;
      logic        sg;
      res_t        w;
   } vec_t;

   res_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   pres_cyc = 0;
   logic rnd_done = 1'b0;
   vec_t dv[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic res_t mk(input logic [22:0] f, input logic [9:0] e, input logic sg,
                               input logic z, input logic ix);
      res_t r;
      r = {f, e, sg, z, ix};
      return r;
   endfunction

   // Reference rounding: compare the discarded remainder against one half-ULP.
   function automatic res_t model(input logic [47:0] p, input logic [9:0] ei, input logic sg);
      longint unsigned pp, m, rem, half;
      int              sh;
      logic [9:0]      e;
      pp   = 64'(p);
      sh   = p[47] ? 1 : 0;
      m    = pp >> (23 + sh);
      rem  = pp & ((64'd1 << (23 + sh)) - 64'd1);
      half = 64'd1 << (22 + sh);
      e    = ei + 10'(sh);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == 64'h1000000) begin
         m = 0;
         e = e + 10'd1;
      end
      return mk(m[22:0], e, sg, p == '0, rem != 0);
   endfunction

   task automatic send(input logic [47:0] c, input logic [47:0] s, input logic [9:0] e,
                       input logic sg, input res_t want);
      int n = 0;
      carry    = c;
      sum      = s;
      exp_in   = e;
      sign_in  = sg;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: actual in_ready=0 required=1");
      end else begin
         pres_cyc = cyc;
         @(posedge clk);
         sb_q.push_back(want);
      end
      #1 in_valid = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops on every output handshake and checks held outputs stay stable.
   initial begin
      res_t cur, last, want;
      logic held;
      held = 1'b0;
      last = '0;
      forever begin
         @(negedge clk);
         cur = {frac_out, exp_out, sign_out, zero_out, inexact_out};
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (out_valid && held) check("hold", 64'(cur), 64'(last));
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: actual=%0h required=none", cur);
               end else begin
                  want = sb_q.pop_front();
                  check("result", 64'(cur), 64'(want));
               end
            end
            held = out_valid && !out_ready;
            last = cur;
         end
      end
   end

   initial begin
      int n;
      dv[0] = '{48'h0, 48'h400000000000, 10'h07F, 1'b0, mk(23'h0, 10'h07F, 1'b0, 1'b0, 1'b0)};
      dv[1] = '{48'h123456789ABC, 48'hEDCBA7876545, 10'h080, 1'b1,
                mk(23'h7FFFFE, 10'h081, 1'b1, 1'b0, 1'b1)};
      dv[2] = '{48'h0, 48'h400000C00000, 10'h100, 1'b0, mk(23'h2, 10'h100, 1'b0, 1'b0, 1'b1)};
      dv[3] = '{48'h0, 48'hFFFFFF800000, 10'h010, 1'b0, mk(23'h0, 10'h012, 1'b0, 1'b0, 1'b1)};
      dv[4] = '{48'h000000C00000, 48'hFFFFFEC00000, 10'h3FE, 1'b1,
                mk(23'h0, 10'h000, 1'b1, 1'b0, 1'b1)};
      dv[5] = '{48'h800000000000, 48'h800000000000, 10'h155, 1'b1,
                mk(23'h0, 10'h155, 1'b1, 1'b1, 1'b0)};
      dv[6] = '{48'h800000800000, 48'h000000800000, 10'h3FF, 1'b0,
                mk(23'h1, 10'h000, 1'b0, 1'b0, 1'b0)};
      dv[7] = '{48'h0, 48'h400000600001, 10'h200, 1'b0, mk(23'h1, 10'h200, 1'b0, 1'b0, 1'b1)};

      #1 rst_n = 1'b0;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_outputs", 64'({frac_out, exp_out, sign_out, zero_out, inexact_out}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency from the presenting cycle of an input to out_valid, empty pipeline.
      send(dv[0].c, dv[0].s, dv[0].e, dv[0].sg, dv[0].w);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", 64'(cyc - pres_cyc), 64'(LAT));
      @(posedge clk);
      #1;

      for (int i = 1; i < 8; i++) send(dv[i].c, dv[i].s, dv[i].e, dv[i].sg, dv[i].w);

      // Six back-to-back inputs into a stalled output.
      out_ready = 1'b0;
      fork
         begin
            repeat (4) @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 6; i++)
               send(dv[i+1].c, dv[i+1].s, dv[i+1].e, dv[i+1].sg, dv[i+1].w);
         end
      join

      // Random a*b with carry/sum split and random backpressure.
      fork
         begin
            for (int i = 0; i < 5000; i++) begin
               logic [23:0] a, b;
               logic [47:0] p, c;
               logic [9:0]  e;
               logic        sg;
               a  = 24'($urandom);
               b  = 24'($urandom);
               if (i[0]) begin
                  a[23] = 1'b1;
                  b[23] = 1'b1;
               end
               p  = 48'(a) * 48'(b);
               c  = {16'($urandom), 32'($urandom)};
               e  = 10'($urandom);
               sg = 1'($urandom);
               send(c, p - c, e, sg, model(p, e, sg));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join

      n = 0;
      while (sb_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb_q.size()), 64'd0);

      // Reset with two entries in flight discards them.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(dv[2].c, dv[2].s, dv[2].e, dv[2].sg, dv[2].w);
      send(dv[3].c, dv[3].s, dv[3].e, dv[3].sg, dv[3].w);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      sb_q.delete();
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_outputs", 64'({frac_out, exp_out, sign_out, zero_out, inexact_out}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);

      send(dv[4].c, dv[4].s, dv[4].e, dv[4].sg, dv[4].w);
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("post_rst_drain", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
